// File: rtl/cpu_step_pkg.sv
// Shared types and constants for the single-step instruction sequencer.
package cpu_step_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_LOAD   = 3'd3,
    ST_DECODE = 3'd4,
    ST_EXEC   = 3'd5,
    ST_WB     = 3'd6,
    ST_HALTED = 3'd7
  } step_state_t;

  // Opcode field: top OP_W bits of the instruction word
  localparam int unsigned OP_W = 4;

  // Default opcode that stops the sequencer once retired
  localparam logic [OP_W-1:0] HALT_OP_DEFAULT = 4'hF;

  // Extract the opcode field from an instruction of width dw
  function automatic logic [OP_W-1:0] opcode_of(input logic [31:0] instr, input int unsigned dw);
    return OP_W'(instr >> (dw - OP_W));
  endfunction

endpackage

// File: rtl/cpu_step_seq.sv
// CPU-side single-step responder: runs one instruction (or a free-running
// stream) through fetch/decode/execute/writeback by strobing phase enables.
module cpu_step_seq
  import cpu_step_pkg::*;
#(
  parameter int unsigned     AW       = 8,
  parameter int unsigned     DW       = 16,
  parameter int unsigned     MEM_LAT  = 1,
  parameter logic [AW-1:0]   PC_RESET = '0,
  parameter logic [OP_W-1:0] HALT_OP  = HALT_OP_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          run,
  output logic [AW-1:0] mem_addr,
  output logic          mem_re,
  input  logic [DW-1:0] mem_rdata,
  input  logic          jmp_en,
  input  logic [AW-1:0] jmp_addr,
  output logic          dec_en,
  output logic          exe_en,
  output logic          wb_en,
  output logic [AW-1:0] pc,
  output logic [DW-1:0] ir,
  output logic          busy,
  output logic          done,
  output logic          halted,
  output logic [15:0]   instr_cnt
);

  localparam int unsigned CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  step_state_t   state;
  logic [CW-1:0] lat_cnt;
  logic          is_halt;

  assign is_halt = (opcode_of(32'(ir), DW) == HALT_OP);

  // Single FSM; every output is set on the edge that enters the state it
  // belongs to, so strobes line up with the state register cycle-for-cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      pc        <= PC_RESET;
      ir        <= '0;
      instr_cnt <= '0;
      mem_addr  <= PC_RESET;
      mem_re    <= 1'b0;
      dec_en    <= 1'b0;
      exe_en    <= 1'b0;
      wb_en     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      halted    <= 1'b0;
      lat_cnt   <= '0;
    end else begin
      mem_re <= 1'b0;
      dec_en <= 1'b0;
      exe_en <= 1'b0;
      wb_en  <= 1'b0;
      done   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start || run) begin
            state    <= ST_FETCH;
            mem_addr <= pc;
            mem_re   <= 1'b1;
            busy     <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (MEM_LAT > 1) begin
            state   <= ST_WAIT;
            lat_cnt <= CW'(MEM_LAT - 2);
          end else begin
            state <= ST_LOAD;
          end
        end
        ST_WAIT: begin
          if (lat_cnt == '0) state <= ST_LOAD;
          else               lat_cnt <= lat_cnt - 1'b1;
        end
        ST_LOAD: begin
          ir     <= mem_rdata;
          pc     <= pc + 1'b1;
          state  <= ST_DECODE;
          dec_en <= 1'b1;
        end
        ST_DECODE: begin
          state  <= ST_EXEC;
          exe_en <= 1'b1;
        end
        ST_EXEC: begin
          if (jmp_en) pc <= jmp_addr;
          state <= ST_WB;
          wb_en <= 1'b1;
          done  <= 1'b1;
          if (instr_cnt != '1) instr_cnt <= instr_cnt + 1'b1;
        end
        ST_WB: begin
          if (is_halt) begin
            state  <= ST_HALTED;
            halted <= 1'b1;
            busy   <= 1'b0;
          end else if (run) begin
            state    <= ST_FETCH;
            mem_addr <= pc;
            mem_re   <= 1'b1;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_HALTED: begin
          state <= ST_HALTED;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_step_seq.sv
// Directed bench for cpu_step_seq: single step, free-run wrap, branch,
// halt, multi-cycle memory latency and mid-instruction reset.
module tb_cpu_step_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- instance A: MEM_LAT=1, PC_RESET=0 ----------------
  logic rst_a = 1'b0, start_a = 1'b0, run_a = 1'b0, jmp_arm = 1'b0;
  logic [7:0] mem_addr_a, pc_a;
  logic mem_re_a, dec_en_a, exe_en_a, wb_en_a, busy_a, done_a, halted_a, jmp_en_a;
  logic [15:0] rdata_a, ir_a, cnt_a;
  logic [15:0] mem_a [256];

  assign jmp_en_a = jmp_arm && exe_en_a && (mem_addr_a == 8'h05);
  always @(posedge clk) rdata_a <= mem_a[mem_addr_a];

  cpu_step_seq #(.AW(8), .DW(16), .MEM_LAT(1), .PC_RESET(8'h00)) dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .run(run_a),
    .mem_addr(mem_addr_a), .mem_re(mem_re_a), .mem_rdata(rdata_a),
    .jmp_en(jmp_en_a), .jmp_addr(8'h40),
    .dec_en(dec_en_a), .exe_en(exe_en_a), .wb_en(wb_en_a),
    .pc(pc_a), .ir(ir_a), .busy(busy_a), .done(done_a),
    .halted(halted_a), .instr_cnt(cnt_a));

  // ---------------- instance B: MEM_LAT=3, PC_RESET=0 ----------------
  logic rst_b = 1'b0, start_b = 1'b0;
  logic [7:0] mem_addr_b, pc_b;
  logic mem_re_b, dec_en_b, exe_en_b, wb_en_b, busy_b, done_b, halted_b;
  logic [15:0] rb0, rb1, rb2, ir_b, cnt_b;
  logic [15:0] mem_b [256];

  always @(posedge clk) begin
    rb0 <= mem_b[mem_addr_b];
    rb1 <= rb0;
    rb2 <= rb1;
  end

  cpu_step_seq #(.AW(8), .DW(16), .MEM_LAT(3), .PC_RESET(8'h00)) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .run(1'b0),
    .mem_addr(mem_addr_b), .mem_re(mem_re_b), .mem_rdata(rb2),
    .jmp_en(1'b0), .jmp_addr(8'h00),
    .dec_en(dec_en_b), .exe_en(exe_en_b), .wb_en(wb_en_b),
    .pc(pc_b), .ir(ir_b), .busy(busy_b), .done(done_b),
    .halted(halted_b), .instr_cnt(cnt_b));

  // ---------------- instance C: MEM_LAT=1, PC_RESET=FE ----------------
  logic rst_c = 1'b0, run_c = 1'b0;
  logic [7:0] mem_addr_c, pc_c;
  logic mem_re_c, dec_en_c, exe_en_c, wb_en_c, busy_c, done_c, halted_c;
  logic [15:0] rdata_c, ir_c, cnt_c;
  logic [15:0] mem_c [256];

  always @(posedge clk) rdata_c <= mem_c[mem_addr_c];

  cpu_step_seq #(.AW(8), .DW(16), .MEM_LAT(1), .PC_RESET(8'hFE)) dut_c (
    .clk(clk), .rst(rst_c), .start(1'b0), .run(run_c),
    .mem_addr(mem_addr_c), .mem_re(mem_re_c), .mem_rdata(rdata_c),
    .jmp_en(1'b0), .jmp_addr(8'h00),
    .dec_en(dec_en_c), .exe_en(exe_en_c), .wb_en(wb_en_c),
    .pc(pc_c), .ir(ir_c), .busy(busy_c), .done(done_c),
    .halted(halted_c), .instr_cnt(cnt_c));

  logic [7:0]  fa [6];
  logic [7:0]  exp_fa [6];
  logic [7:0]  waddr [3];
  logic [15:0] wdata [3];
  logic [7:0]  npc;
  int nf;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 16'h0000;
      mem_b[i] = 16'h0000;
      mem_c[i] = 16'h0000;
    end
    mem_a[0]     = 16'h1234;
    mem_a[1]     = 16'h0101;
    mem_a[2]     = 16'h0202;
    mem_a[3]     = 16'h0303;
    mem_a[4]     = 16'h0404;
    mem_a[5]     = 16'h0505;
    mem_a[8'h40] = 16'hF000;
    mem_b[0]     = 16'hABCD;
    mem_c[8'hFE] = 16'h2222;
    mem_c[8'hFF] = 16'h3333;
    mem_c[8'h00] = 16'h4444;

    // Reset: two cycles low
    tick(); tick();
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    tick();
    chk("rst_pc",     32'(pc_a), 32'h00);
    chk("rst_ir",     32'(ir_a), 32'h0);
    chk("rst_maddr",  32'(mem_addr_a), 32'h00);
    chk("rst_strobe", {28'd0, mem_re_a, dec_en_a, exe_en_a, wb_en_a}, 32'h0);
    chk("rst_flags",  {29'd0, busy_a, done_a, halted_a}, 32'h0);
    chk("rst_cnt",    32'(cnt_a), 32'h0);
    chk("rst_pc_c",   32'(pc_c), 32'hFE);

    // Single step on A: FETCH k+1 .. WB k+5
    start_a = 1'b1;
    tick(); start_a = 1'b0;
    chk("s1_fetch",  {29'd0, mem_re_a, busy_a, dec_en_a}, 32'b110);
    chk("s1_maddr",  32'(mem_addr_a), 32'h00);
    tick();
    chk("s1_load",   {28'd0, mem_re_a, dec_en_a, exe_en_a, wb_en_a}, 32'h0);
    tick();
    chk("s1_dec",    {28'd0, mem_re_a, dec_en_a, exe_en_a, wb_en_a}, 32'b0100);
    chk("s1_ir",     32'(ir_a), 32'h1234);
    chk("s1_pc",     32'(pc_a), 32'h01);
    tick();
    chk("s1_exe",    {28'd0, mem_re_a, dec_en_a, exe_en_a, wb_en_a}, 32'b0010);
    chk("s1_exdone", 32'(done_a), 32'h0);
    tick();
    chk("s1_wb",     {28'd0, mem_re_a, dec_en_a, exe_en_a, wb_en_a}, 32'b0001);
    chk("s1_done",   32'(done_a), 32'h1);
    chk("s1_cnt",    32'(cnt_a), 32'h1);
    tick();
    chk("s1_idle",   {29'd0, busy_a, done_a, mem_re_a}, 32'h0);
    tick();
    chk("s1_stay",   {30'd0, busy_a, mem_re_a}, 32'h0);

    // Free-run wrap on C: FE, FF, 00 back-to-back, run dropped during the third
    waddr[0] = 8'hFE; waddr[1] = 8'hFF; waddr[2] = 8'h00;
    wdata[0] = 16'h2222; wdata[1] = 16'h3333; wdata[2] = 16'h4444;
    run_c = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("w%0d_re", i),    32'(mem_re_c), 32'h1);
      chk($sformatf("w%0d_addr", i),  32'(mem_addr_c), 32'(waddr[i]));
      if (i == 2) run_c = 1'b0;
      tick(); tick();
      npc = waddr[i] + 8'd1;
      chk($sformatf("w%0d_ir", i),    32'(ir_c), 32'(wdata[i]));
      chk($sformatf("w%0d_pc", i),    32'(pc_c), 32'(npc));
      chk($sformatf("w%0d_dec", i),   32'(dec_en_c), 32'h1);
      tick();
      chk($sformatf("w%0d_exe", i),   32'(exe_en_c), 32'h1);
      tick();
      chk($sformatf("w%0d_done", i),  {30'd0, wb_en_c, done_c}, 32'b11);
      chk($sformatf("w%0d_cnt", i),   32'(cnt_c), 32'(i + 1));
    end
    tick();
    chk("w_idle", {30'd0, busy_c, mem_re_c}, 32'h0);

    // Free-run on A from pc=1, branch to 0x40 out of EXEC of pc=5, then halt
    exp_fa[0] = 8'h01; exp_fa[1] = 8'h02; exp_fa[2] = 8'h03;
    exp_fa[3] = 8'h04; exp_fa[4] = 8'h05; exp_fa[5] = 8'h40;
    run_a = 1'b1; jmp_arm = 1'b1; nf = 0;
    for (int i = 0; i < 80 && nf < 6; i++) begin
      tick();
      if (mem_re_a) begin
        fa[nf] = mem_addr_a;
        nf++;
      end
    end
    chk("j_nfetch", 32'(nf), 32'd6);
    for (int i = 0; i < 6; i++)
      if (i < nf) chk($sformatf("j_fa%0d", i), 32'(fa[i]), 32'(exp_fa[i]));
    tick(); tick();
    chk("h_ir",     32'(ir_a), 32'hF000);
    chk("h_pc",     32'(pc_a), 32'h41);
    tick(); tick();
    chk("h_done",   {30'd0, done_a, halted_a}, 32'b10);
    chk("h_cnt",    32'(cnt_a), 32'd7);
    tick();
    chk("h_halt",   {29'd0, halted_a, busy_a, done_a}, 32'b100);
    start_a = 1'b1;
    tick(); start_a = 1'b0;
    tick(); tick();
    chk("h_ignore", {29'd0, halted_a, busy_a, mem_re_a}, 32'b100);
    chk("h_cnt2",   32'(cnt_a), 32'd7);
    chk("h_pc2",    32'(pc_a), 32'h41);
    run_a = 1'b0; jmp_arm = 1'b0; rst_a = 1'b0;
    tick();
    chk("h_clr",    32'(halted_a), 32'h0);
    chk("h_clrpc",  32'(pc_a), 32'h00);
    chk("h_clrcnt", 32'(cnt_a), 32'h0);
    rst_a = 1'b1;

    // MEM_LAT=3 on B, with start pulses while busy
    start_b = 1'b1;
    tick(); start_b = 1'b0;
    chk("l_fetch",  {30'd0, mem_re_b, busy_b}, 32'b11);
    tick();
    chk("l_wait1",  {30'd0, mem_re_b, busy_b}, 32'b01);
    start_b = 1'b1;
    tick(); start_b = 1'b0;
    chk("l_wait2",  {29'd0, mem_re_b, dec_en_b, busy_b}, 32'b001);
    tick();
    chk("l_load",   32'(ir_b), 32'h0);
    chk("l_loadde", 32'(dec_en_b), 32'h0);
    tick();
    chk("l_ir",     32'(ir_b), 32'hABCD);
    chk("l_dec",    32'(dec_en_b), 32'h1);
    tick(); tick();
    chk("l_done",   {30'd0, wb_en_b, done_b}, 32'b11);
    tick();
    chk("l_noqueue", {30'd0, busy_b, mem_re_b}, 32'h0);
    chk("l_cnt",    32'(cnt_b), 32'h1);

    // Reset during EXEC on B: no writeback, back to reset state
    start_b = 1'b1;
    tick(); start_b = 1'b0;
    tick(); tick(); tick(); tick(); tick();
    chk("r_exec",   32'(exe_en_b), 32'h1);
    rst_b = 1'b0;
    tick();
    chk("r_nowb",   {29'd0, wb_en_b, done_b, exe_en_b}, 32'h0);
    chk("r_busy",   32'(busy_b), 32'h0);
    chk("r_pc",     32'(pc_b), 32'h00);
    chk("r_cnt",    32'(cnt_b), 32'h0);
    rst_b = 1'b1;
    tick();
    chk("r_idle",   {30'd0, busy_b, mem_re_b}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_step_seq.md
Name: cpu_step_seq

Overview:
- CPU-side responder of the single-step debug interface.
- Accepts the one-cycle `start` pulse issued by the FPGA step controller and sequences exactly one instruction through fetch/decode/execute/writeback by strobing datapath phase enables.
- Exports `pc`/`ir` for the debug display and reports completion.
- Sits inside the CPU, between the step controller and the datapath/instruction memory.

Parameters:
- AW, 8, program counter / instruction address width
- DW, 16, instruction width
- MEM_LAT, 1, instruction memory read latency in cycles (>=1)
- PC_RESET, 0, program counter value after reset
- HALT_OP, 4'hF, opcode in ir[DW-1:DW-4] that halts the sequencer

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-low
- start  input  1  single-cycle step request from step controller
- run  input  1  1 = free-run consecutive instructions, 0 = one instruction per start
- mem_addr  output  AW  instruction fetch address
- mem_re  output  1  instruction memory read strobe
- mem_rdata  input  DW  instruction data, valid MEM_LAT cycles after mem_re
- jmp_en  input  1  branch taken, from datapath, sampled only in EXEC
- jmp_addr  input  AW  branch target
- dec_en  output  1  decode phase strobe
- exe_en  output  1  execute phase strobe
- wb_en  output  1  register writeback strobe
- pc  output  AW  current program counter
- ir  output  DW  current instruction register
- busy  output  1  instruction in flight
- done  output  1  one-cycle pulse, instruction retired
- halted  output  1  HALT_OP retired; sequencer stopped
- instr_cnt  output  16  retired-instruction counter

Behaviour:
- One clock. Reset is synchronous and active-low on rst: all state is updated on the rising clk edge, and rst=0 sampled at an edge resets the block.
- Reset values: state=IDLE, pc=PC_RESET, ir=0, instr_cnt=0, mem_addr=PC_RESET, and mem_re, dec_en, exe_en, wb_en, busy, done, halted all 0.
- Reset mid-instruction aborts immediately. There is no partial writeback: wb_en is 0 in the reset cycle.
- States and transitions:
  - IDLE: busy=0. start=1 or run=1 -> FETCH.
  - FETCH: mem_addr=pc, mem_re=1 for exactly 1 cycle. -> WAIT if MEM_LAT>1, else -> LOAD.
  - WAIT: hold for MEM_LAT-1 cycles using an internal down-counter. -> LOAD.
  - LOAD: ir<=mem_rdata; pc<=pc+1, with modulo 2^AW wrap (8'hFF -> 8'h00). -> DECODE.
  - DECODE: dec_en=1. -> EXEC.
  - EXEC: exe_en=1. If jmp_en=1, pc<=jmp_addr, overriding the increment. -> WB.
  - WB: wb_en=1, done=1, instr_cnt+1 (saturates at 16'hFFFF). Next state:
    - ir[DW-1:DW-4]==HALT_OP -> HALTED
    - else run=1 -> FETCH
    - else -> IDLE
  - HALTED: halted=1, busy=0. start and run are ignored. Leaves only on reset.
- busy=1 in every state except IDLE and HALTED.
- Latency for MEM_LAT=1, start sampled at edge k: FETCH at k+1, LOAD at k+2, DECODE at k+3, EXEC at k+4, WB/done at k+5. This gives 5 cycles per instruction in run mode.
- start while busy is ignored and not queued.
- start and run both high in IDLE start one sequence only.
- run dropped mid-instruction: the current instruction completes, then the sequencer goes to IDLE.
- All outputs are registered; the phase strobes are mutually exclusive.

Decomposition:
- Package `cpu_step_pkg` holds:
  - the state encoding (IDLE, FETCH, WAIT, LOAD, DECODE, EXEC, WB, HALTED)
  - the HALT_OP default
  - the opcode field position constants
- Single module; no sub-module needed. The latency down-counter stays inline.

Test Plan:
- Reset with rst=0 for 2 cycles, then rst=1 -> pc=0, ir=0, busy=0, all strobes 0, instr_cnt=0.
- Memory word 0=16'h1234, one start pulse, run=0 -> mem_re at k+1, ir=16'h1234 after k+2, dec/exe/wb strobes at k+3/k+4/k+5, done once, pc=1, instr_cnt=1, back to IDLE.
- run=1, no branches, pc preloaded to 8'hFE -> instructions at 8'hFE, 8'hFF, 8'h00 fetched back-to-back every 5 cycles; pc wraps to 0.
- jmp_en=1 with jmp_addr=8'h40 during EXEC of instruction at pc=5 -> next mem_addr=8'h40, not 6.
- Instruction 16'hF000 -> done pulse, halted=1, busy=0. Further start/run pulses change nothing. rst=0 clears halted.
- MEM_LAT=3 build -> ir latched 3 cycles after mem_re. start pulses during busy are ignored. rst=0 during EXEC -> no wb_en; state is IDLE with pc=PC_RESET.
